// File: rtl/hub75_pkg.sv
// Shared types and word layout for the HUB75 column datapath.
// Framebuffer word is {r1,g1,b1,r0,g0,b0}; field k occupies bits [k*COLOR_BITS +: COLOR_BITS].
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  localparam int FLD_B0     = 0;
  localparam int FLD_G0     = 1;
  localparam int FLD_R0     = 2;
  localparam int FLD_B1     = 3;
  localparam int FLD_G1     = 4;
  localparam int FLD_R1     = 5;
  localparam int NUM_FIELDS = 6;

  function automatic int col_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

  function automatic int plane_w(input int color_bits);
    return (color_bits > 1) ? $clog2(color_bits) : 1;
  endfunction

endpackage

// File: rtl/hub75_pixel_select.sv
// Combinational bit-plane extraction: one bit per colour field, or colour bars in test mode.
// A plane index at or beyond COLOR_BITS shifts the mask out and yields all-zero data.
module hub75_pixel_select
  import hub75_pkg::*;
#(
  parameter  int COLOR_BITS = 4,
  localparam int PLANE_W    = plane_w(COLOR_BITS)
) (
  input  logic [NUM_FIELDS*COLOR_BITS-1:0] rdata_i,
  input  logic [PLANE_W-1:0]               plane_i,
  input  logic                             test_en_i,
  input  logic [2:0]                       bar_col_i,
  output logic [1:0]                       data_r_o,
  output logic [1:0]                       data_g_o,
  output logic [1:0]                       data_b_o
);

  logic [COLOR_BITS-1:0] plane_mask;
  logic [NUM_FIELDS-1:0] ram_bits;
  logic [NUM_FIELDS-1:0] bar_bits;
  logic [NUM_FIELDS-1:0] sel_bits;

  assign plane_mask = COLOR_BITS'(1) << plane_i;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign ram_bits[k] = |(rdata_i[k*COLOR_BITS +: COLOR_BITS] & plane_mask);
  end

  // Upper half {r,g,b} = col[2:0], lower half is the inverse.
  assign bar_bits = {~bar_col_i, bar_col_i};
  assign sel_bits = test_en_i ? bar_bits : ram_bits;

  assign data_r_o = {sel_bits[FLD_R1], sel_bits[FLD_R0]};
  assign data_g_o = {sel_bits[FLD_G1], sel_bits[FLD_G0]};
  assign data_b_o = {sel_bits[FLD_B1], sel_bits[FLD_B0]};

endmodule

// File: rtl/hub75_column_shifter.sv
// HUB75 row shifter: reads {row,col} words, shifts one bit-plane per column, flags end of row.
// Define HUB75_TEST_PATTERN_EN to add i_test_en, which replaces RAM data with colour bars.
module hub75_column_shifter
  import hub75_pkg::*;
#(
  parameter  int COLS       = 64,
  parameter  int ROW_W      = 5,
  parameter  int COLOR_BITS = 4,
  localparam int COL_W      = col_w(COLS),
  localparam int PLANE_W    = plane_w(COLOR_BITS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
`ifdef HUB75_TEST_PATTERN_EN
  input  logic                             i_test_en,
`endif
  input  logic                             i_add_columns,
  input  logic                             i_rst_columns,
  input  logic [ROW_W-1:0]                 i_row,
  input  logic [PLANE_W-1:0]               i_plane,
  output logic                             o_comp_columns,
  output logic [ROW_W+COL_W-1:0]           o_mem_addr,
  input  logic [NUM_FIELDS*COLOR_BITS-1:0] i_mem_rdata,
  output logic                             o_pix_clk,
  output logic [1:0]                       o_data_r,
  output logic [1:0]                       o_data_g,
  output logic [1:0]                       o_data_b
);

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W+COL_W-1:0]   addr_q, addr_d;
  logic [1:0]               data_r_q, data_r_d, data_g_q, data_g_d, data_b_q, data_b_d;
  logic                     pix_q, pix_d, comp_q, comp_d;
  logic [1:0]               sel_r, sel_g, sel_b;
  logic [2:0]               bar_col;
  logic                     test_en;

`ifdef HUB75_TEST_PATTERN_EN
  assign test_en = i_test_en;
`else
  assign test_en = 1'b0;
`endif

  if (COL_W >= 3) begin : g_bar_wide
    assign bar_col = col_q[2:0];
  end else begin : g_bar_narrow
    assign bar_col = {{(3-COL_W){1'b0}}, col_q};
  end

  hub75_pixel_select #(
    .COLOR_BITS (COLOR_BITS)
  ) u_pixel_select (
    .rdata_i   (i_mem_rdata),
    .plane_i   (i_plane),
    .test_en_i (test_en),
    .bar_col_i (bar_col),
    .data_r_o  (sel_r),
    .data_g_o  (sel_g),
    .data_b_o  (sel_b)
  );

  // pix_clk and comp are registered from the current state, so each lags its state by one cycle;
  // this gives the data a full cycle of setup ahead of the pix_clk rise.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    addr_d   = addr_q;
    data_r_d = data_r_q;
    data_g_d = data_g_q;
    data_b_d = data_b_q;
    pix_d    = 1'b0;
    comp_d   = 1'b0;
    if (i_rst_columns) begin
      state_d = ST_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          col_d = '0;
          if (i_add_columns) state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = {i_row, col_q};
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          data_r_d = sel_r;
          data_g_d = sel_g;
          data_b_d = sel_b;
          state_d  = ST_CLK_HI;
        end
        ST_CLK_HI: begin
          pix_d = 1'b1;
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = ST_DONE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_ADDR;
          end
        end
        ST_DONE: comp_d = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      addr_q   <= '0;
      data_r_q <= '0;
      data_g_q <= '0;
      data_b_q <= '0;
      pix_q    <= 1'b0;
      comp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      data_r_q <= data_r_d;
      data_g_q <= data_g_d;
      data_b_q <= data_b_d;
      pix_q    <= pix_d;
      comp_q   <= comp_d;
    end
  end

  assign o_comp_columns = comp_q;
  assign o_mem_addr     = addr_q;
  assign o_pix_clk      = pix_q;
  assign o_data_r       = data_r_q;
  assign o_data_g       = data_g_q;
  assign o_data_b       = data_b_q;

endmodule

// File: tb/tb_hub75_column_shifter.sv
// Directed bench for hub75_column_shifter: main 64-column instance plus a 4-column, 3-plane
// instance that makes an out-of-range plane index reachable.
module tb_hub75_column_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, add, rstc, use_const;
  logic [4:0]  row;
  logic [1:0]  plane;
  logic [23:0] const_word, rdata;
  logic        comp, pix;
  logic [10:0] addr;
  logic [1:0]  dr, dg, db;
`ifdef HUB75_TEST_PATTERN_EN
  logic        test_en;
`endif

  logic        add2, rstc2;
  logic [1:0]  plane2;
  logic [17:0] rdata2;
  logic        comp2, pix2;
  logic [6:0]  addr2;
  logic [1:0]  dr2, dg2, db2;

  int checks = 0;
  int errors = 0;

  assign rdata  = use_const ? const_word : {13'b0, addr};
  assign rdata2 = {3'b010, 3'b111, 3'b111, 3'b101, 3'b111, 3'b111};

  hub75_column_shifter #(.COLS(64), .ROW_W(5), .COLOR_BITS(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
`ifdef HUB75_TEST_PATTERN_EN
    .i_test_en      (test_en),
`endif
    .i_add_columns  (add),
    .i_rst_columns  (rstc),
    .i_row          (row),
    .i_plane        (plane),
    .o_comp_columns (comp),
    .o_mem_addr     (addr),
    .i_mem_rdata    (rdata),
    .o_pix_clk      (pix),
    .o_data_r       (dr),
    .o_data_g       (dg),
    .o_data_b       (db)
  );

  hub75_column_shifter #(.COLS(4), .ROW_W(5), .COLOR_BITS(3)) dut2 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
`ifdef HUB75_TEST_PATTERN_EN
    .i_test_en      (1'b0),
`endif
    .i_add_columns  (add2),
    .i_rst_columns  (rstc2),
    .i_row          (5'd9),
    .i_plane        (plane2),
    .o_comp_columns (comp2),
    .o_mem_addr     (addr2),
    .i_mem_rdata    (rdata2),
    .o_pix_clk      (pix2),
    .o_data_r       (dr2),
    .o_data_g       (dg2),
    .o_data_b       (db2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_add();
    add = 1'b1;
    cyc();
    add = 1'b0;
  endtask

  task automatic abort_row();
    rstc = 1'b1;
    cyc();
    rstc = 1'b0;
    cyc();
  endtask

  // n = cycles until pix_clk is seen high, or -1 if the budget runs out.
  task automatic wait_pix(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (pix === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; add = 1'b0; rstc = 1'b0; row = '0; plane = '0;
    use_const = 1'b0; const_word = '0;
    add2 = 1'b0; rstc2 = 1'b0; plane2 = '0;
`ifdef HUB75_TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    repeat (2) cyc();
    checks++;
    if ({comp, pix, addr, dr, dg, db} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {comp, pix, addr, dr, dg, db});
    end
    rst_n = 1'b1;
    repeat (5) cyc();
    checks++;
    if ({comp, pix, addr} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h required 0", {comp, pix, addr});
    end
  endtask

  task automatic test_async_reset();
    int n;
    int hits;
    row = 5'd3; plane = 2'd0; use_const = 1'b0;
    pulse_add();
    for (int c = 0; c <= 20; c++) begin
      wait_pix(6, n);
      if (n < 0) begin
        checks++; errors++;
        $display("FAIL async_run: no pix_clk pulse for col %0d", c);
        return;
      end
    end
    checks++;
    if (addr !== {5'd3, 6'd20}) begin
      errors++;
      $display("FAIL async_col20_addr: got %h required %h", addr, {5'd3, 6'd20});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({comp, pix, addr, dr, dg, db} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h required 0", {comp, pix, addr, dr, dg, db});
    end
    #3 rst_n = 1'b1;
    hits = 0;
    repeat (10) begin
      cyc();
      if (pix === 1'b1 || comp === 1'b1) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL async_stays_idle: got %0d active cycles required 0", hits);
    end
    pulse_add();
    wait_pix(6, n);
    checks++;
    if (n !== 3 || addr !== {5'd3, 6'd0}) begin
      errors++;
      $display("FAIL async_restart: got rise %0d addr %h required rise 3 addr %h", n, addr, {5'd3, 6'd0});
    end
    abort_row();
  endtask

  task automatic test_full_row();
    int rises;
    int first_comp;
    logic [10:0] a;
    row = 5'd5; plane = 2'd0; use_const = 1'b0;
    rises = 0; first_comp = -1;
    pulse_add();
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (pix === 1'b1) begin
        a = {5'd5, 6'(rises)};
        checks++;
        if (i !== 3 * rises + 3) begin
          errors++;
          $display("FAIL row_rise_time col %0d: got cycle %0d required %0d", rises, i, 3 * rises + 3);
        end
        checks++;
        if (addr !== a) begin
          errors++;
          $display("FAIL row_addr col %0d: got %h required %h", rises, addr, a);
        end
        checks++;
        if ({dr, dg, db} !== {1'b0, a[8], 1'b0, a[4], 1'b0, a[0]}) begin
          errors++;
          $display("FAIL row_data col %0d: got %b required %b", rises, {dr, dg, db},
                   {1'b0, a[8], 1'b0, a[4], 1'b0, a[0]});
        end
        rises++;
      end
      if (comp === 1'b1 && first_comp < 0) first_comp = i;
    end
    checks++;
    if (rises !== 64) begin
      errors++;
      $display("FAIL row_rise_count: got %0d required 64", rises);
    end
    checks++;
    if (first_comp !== 193) begin
      errors++;
      $display("FAIL row_comp_time: got %0d required 193", first_comp);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (comp !== 1'b1 || pix !== 1'b0 || addr !== {5'd5, 6'd63}) begin
        errors++;
        $display("FAIL done_hold cycle %0d: got comp %b pix %b addr %h required 1 0 %h",
                 i, comp, pix, addr, {5'd5, 6'd63});
      end
    end
    rstc = 1'b1;
    cyc();
    rstc = 1'b0;
    checks++;
    if (comp !== 1'b0 || pix !== 1'b0 || addr !== {5'd5, 6'd63}) begin
      errors++;
      $display("FAIL done_release: got comp %b pix %b addr %h required 0 0 %h",
               comp, pix, addr, {5'd5, 6'd63});
    end
    cyc();
  endtask

  task automatic test_abort();
    int n;
    int hits;
    row = 5'd7; plane = 2'd0; use_const = 1'b0;
    pulse_add();
    for (int c = 0; c <= 10; c++) begin
      wait_pix(6, n);
      if (n < 0) begin
        checks++; errors++;
        $display("FAIL abort_run: no pix_clk pulse for col %0d", c);
        return;
      end
    end
    rstc = 1'b1;
    cyc();
    rstc = 1'b0;
    checks++;
    if (pix !== 1'b0 || comp !== 1'b0 || addr !== {5'd7, 6'd10}) begin
      errors++;
      $display("FAIL abort_next_cycle: got pix %b comp %b addr %h required 0 0 %h",
               pix, comp, addr, {5'd7, 6'd10});
    end
    hits = 0;
    repeat (8) begin
      cyc();
      if (pix === 1'b1 || addr !== {5'd7, 6'd10}) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL abort_idle: got %0d active cycles required 0", hits);
    end
    pulse_add();
    cyc();
    checks++;
    if (addr !== {5'd7, 6'd0}) begin
      errors++;
      $display("FAIL abort_restart_addr: got %h required %h", addr, {5'd7, 6'd0});
    end
    wait_pix(6, n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL abort_restart_rise: got %0d required 2", n);
    end
    abort_row();
    add = 1'b1; rstc = 1'b1;
    cyc();
    add = 1'b0; rstc = 1'b0;
    hits = 0;
    repeat (6) begin
      cyc();
      if (pix === 1'b1 || addr !== {5'd7, 6'd0}) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL add_rst_collision: got %0d active cycles required 0", hits);
    end
  endtask

  task automatic test_plane_select();
    logic [1:0] exp_r [4];
    int n;
    int rises;
    int first_comp;
    exp_r[0] = 2'b01; exp_r[1] = 2'b10; exp_r[2] = 2'b01; exp_r[3] = 2'b10;
    use_const = 1'b1; const_word = 24'hA00500; row = 5'd2;
    for (int p = 0; p < 4; p++) begin
      plane = 2'(p);
      pulse_add();
      wait_pix(6, n);
      checks++;
      if (n !== 3 || dr !== exp_r[p] || {dg, db} !== 4'b0000) begin
        errors++;
        $display("FAIL plane%0d_data: got rise %0d r %b gb %b required 3 %b 0000",
                 p, n, dr, {dg, db}, exp_r[p]);
      end
      abort_row();
    end
    plane2 = 2'd0; rises = 0; first_comp = -1;
    add2 = 1'b1;
    cyc();
    add2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (pix2 === 1'b1) begin
        checks++;
        if ({dr2, dg2, db2} !== 6'b01_11_11 || addr2 !== {5'd9, 2'(rises)}) begin
          errors++;
          $display("FAIL small_plane0 col %0d: got %b addr %h required 011111 %h",
                   rises, {dr2, dg2, db2}, addr2, {5'd9, 2'(rises)});
        end
        rises++;
      end
      if (comp2 === 1'b1 && first_comp < 0) first_comp = i;
    end
    checks++;
    if (rises !== 4 || first_comp !== 13) begin
      errors++;
      $display("FAIL small_row_timing: got %0d rises comp at %0d required 4 and 13", rises, first_comp);
    end
    rstc2 = 1'b1;
    cyc();
    rstc2 = 1'b0;
    plane2 = 2'd3;
    add2 = 1'b1;
    cyc();
    add2 = 1'b0;
    repeat (3) cyc();
    checks++;
    if (pix2 !== 1'b1 || {dr2, dg2, db2} !== 6'b0) begin
      errors++;
      $display("FAIL plane_out_of_range: got pix %b data %b required 1 000000", pix2, {dr2, dg2, db2});
    end
    rstc2 = 1'b1;
    cyc();
    rstc2 = 1'b0;
  endtask

`ifdef HUB75_TEST_PATTERN_EN
  task automatic test_pattern();
    int n;
    test_en = 1'b1; use_const = 1'b1; const_word = 24'hFFFFFF;
    row = 5'd1; plane = 2'd0;
    pulse_add();
    for (int c = 0; c <= 5; c++) begin
      wait_pix(6, n);
      if (n < 0) begin
        checks++; errors++;
        $display("FAIL pattern_run: no pix_clk pulse for col %0d", c);
        test_en = 1'b0;
        return;
      end
      if (c == 0) begin
        checks++;
        if ({dr, dg, db} !== 6'b10_10_10) begin
          errors++;
          $display("FAIL pattern_col0: got %b required 101010", {dr, dg, db});
        end
      end
    end
    checks++;
    if ({dr, dg, db} !== 6'b01_10_01 || addr !== {5'd1, 6'd5}) begin
      errors++;
      $display("FAIL pattern_col5: got %b addr %h required 011001 %h", {dr, dg, db}, addr, {5'd1, 6'd5});
    end
    test_en = 1'b0;
    abort_row();
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_full_row();
    test_done_hold();
    test_abort();
    test_plane_select();
`ifdef HUB75_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
